baccarat_sequencer: RTL and testbench
=====================================

Name: baccarat_sequencer

Overview:
- Controller that sequences the card-dealing datapath for one round of baccarat.
- Issues one-hot load strobes for the six card registers (player 1..3, dealer 1..3).
- Decides third-card draws from the live hand scores and player card 3, using punto-banco rules.
- Drives the win lights once the round resolves; sits between the top level and the datapath on the same slow_clock.

Parameters:
- NATURAL_MIN, 8, two-card score at or above which either hand ends the round (natural).
- PLAYER_DRAW_MAX, 5, player two-card score at or below which the player draws a third card.

Ports:
- slow_clock  input  1  sole clock; one deal action per qualified edge.
- resetb  input  1  asynchronous reset, active-high.
- step  input  1  advance enable; a state advances only on an edge where step=1.
- pscore  input  4  player hand score 0..9 (combinational from the card registers).
- dscore  input  4  dealer hand score 0..9.
- pcard3  input  4  player third card rank: 0=none, 1=A .. 13=K.
- load_pcard1, load_pcard2, load_pcard3  output  1 each  player card register load strobes.
- load_dcard1, load_dcard2, load_dcard3  output  1 each  dealer card register load strobes.
- done  output  1  round resolved.
- player_win_light  output  1  player wins, or tie.
- dealer_win_light  output  1  dealer wins, or tie.

Behaviour:
- States: S_P1, S_D1, S_P2, S_D2, S_THIRD, S_BANK3, S_DONE. Reset state is S_P1.
- Reset values: all outputs are 0 while resetb=1, asynchronously, regardless of step.
- Load strobes are combinational: (state decode) AND step. At most one strobe is high in any cycle.
- A strobe high during an edge loads the card register at that same edge. Scores are valid the cycle after.
- step=0: state holds and all strobes are 0.
- Fixed deal order, one state per card:
  - S_P1 asserts load_pcard1, then goes to S_D1.
  - S_D1 asserts load_dcard1, then goes to S_P2.
  - S_P2 asserts load_pcard2, then goes to S_D2.
  - S_D2 asserts load_dcard2, then goes to S_THIRD.
- S_THIRD (two-card scores valid), first matching rule wins:
  - pscore >= NATURAL_MIN or dscore >= NATURAL_MIN: no load; go to S_DONE.
  - else pscore <= PLAYER_DRAW_MAX: load_pcard3; go to S_BANK3.
  - else (player stands) dscore <= 5: load_dcard3; go to S_DONE.
  - else: no load; go to S_DONE.
- S_BANK3: compute v = face value of pcard3 (ranks 10..13 give 0, else the rank). Dealer draws (load_dcard3) when:
  - dscore 0..2: always.
  - dscore 3: v != 8.
  - dscore 4: v in 2..7.
  - dscore 5: v in 4..7.
  - dscore 6: v in 6..7.
  - dscore 7: never.
  - Either way, go to S_DONE.
- S_DONE: terminal until reset; step is ignored.
  - done=1.
  - pscore > dscore: player_win_light=1.
  - dscore > pscore: dealer_win_light=1.
  - Equal scores: both lights = 1.
  - Lights are combinational from the scores while in S_DONE and are 0 in every other state.
- Arithmetic: 4-bit unsigned compares. Input scores > 9 do not occur and are don't-care.
- Reset mid-round: state returns to S_P1 immediately and strobes drop in the same cycle. The datapath is cleared by the same reset.

Optional Feature:
- Macro: BACCARAT_STATE_DBG_EN.
- Defined: adds output state_dbg [2:0], the encoded current state.
  - Encoding: S_P1=0, S_D1=1, S_P2=2, S_D2=3, S_THIRD=4, S_BANK3=5, S_DONE=6.
  - Reset value 0.
- Undefined: port absent; behaviour otherwise identical.

Decomposition:
- baccarat_pkg:
  - state enum with the encoding above.
  - rank constants RANK_NONE=0 and RANK_TEN=10.
  - face_value function (rank to 0..9).
- Sub-module banker_draw: purely combinational (dscore, pcard3 -> draw). Instantiated once in S_BANK3 decode.

Test Plan:
- Natural: reset; step x4; drive pscore=9, dscore=3 -> only load_pcard1, load_dcard1, load_pcard2, load_dcard2 pulse, in that order; no third loads; done=1; player_win_light=1, dealer_win_light=0.
- Player draws, banker 3 vs 8: after 4 steps, pscore=4, dscore=3; step -> load_pcard3; set pcard3=8; step -> no load_dcard3; done=1.
- Player draws, banker 6 vs 7: pscore=2, dscore=6, pcard3=7 -> load_dcard3 in S_BANK3. Repeat with pcard3=12 (v=0) -> no load_dcard3.
- Player stands, banker draws: pscore=7, dscore=5 -> load_dcard3 in S_THIRD, next state S_DONE. With pscore=6, dscore=6 -> no third loads; both lights = 1 (tie).
- step gating: hold step=0 for 10 cycles in S_P2 -> all strobes 0, state unchanged; assert step -> load_pcard2 for exactly one cycle.
- Mid-round reset: assert resetb asynchronously while load_dcard1 is high -> strobe drops with no clock edge; after release, the first step gives load_pcard1.

Source files
------------

// File: rtl/baccarat_pkg.sv
// Shared types and helpers for the baccarat round sequencer.
// State encoding, card rank constants and the rank-to-face-value mapping.
package baccarat_pkg;

   typedef enum logic [2:0] {
      S_P1    = 3'd0,
      S_D1    = 3'd1,
      S_P2    = 3'd2,
      S_D2    = 3'd3,
      S_THIRD = 3'd4,
      S_BANK3 = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   localparam logic [3:0] RANK_NONE       = 4'd0;
   localparam logic [3:0] RANK_TEN        = 4'd10;
   // Dealer two-card total at or below which a dealer facing a standing player draws.
   localparam logic [3:0] DEALER_DRAW_MAX = 4'd5;

   // Ten and the court cards count zero; an absent card also counts zero.
   function automatic logic [3:0] face_value(input logic [3:0] rank);
      logic [3:0] v;
      if ((rank == RANK_NONE) || (rank >= RANK_TEN)) begin
         v = 4'd0;
      end else begin
         v = rank;
      end
      return v;
   endfunction

endpackage

// File: rtl/banker_draw.sv
// Banker third-card decision once the player has drawn a third card.
// Purely combinational: dealer two-card score and player third card rank in,
// draw decision out.
module banker_draw
   import baccarat_pkg::*;
(
   input  logic [3:0] dscore,
   input  logic [3:0] pcard3,
   output logic       draw
);

   logic [3:0] v_s;

   // Punto-banco tableau indexed by dealer score and the player's third-card value.
   always_comb begin
      v_s  = face_value(pcard3);
      draw = 1'b0;
      case (dscore)
         4'd0, 4'd1, 4'd2: draw = 1'b1;
         4'd3:             draw = (v_s != 4'd8);
         4'd4:             draw = (v_s >= 4'd2) && (v_s <= 4'd7);
         4'd5:             draw = (v_s >= 4'd4) && (v_s <= 4'd7);
         4'd6:             draw = (v_s >= 4'd6) && (v_s <= 4'd7);
         default:          draw = 1'b0;
      endcase
   end

endmodule

// File: rtl/baccarat_sequencer.sv
// Baccarat round sequencer: deals four cards in fixed order, decides third
// cards from the live hand scores and drives the win lights at round end.
// Load strobes are state decode gated by step and are forced low during reset.
// Optional macro BACCARAT_STATE_DBG_EN adds the state_dbg[2:0] output.
module baccarat_sequencer
   import baccarat_pkg::*;
#(
   parameter logic [3:0] NATURAL_MIN     = 4'd8,
   parameter logic [3:0] PLAYER_DRAW_MAX = 4'd5
)(
   input  logic       slow_clock,
   input  logic       resetb,
   input  logic       step,
   input  logic [3:0] pscore,
   input  logic [3:0] dscore,
   input  logic [3:0] pcard3,
   output logic       load_pcard1,
   output logic       load_pcard2,
   output logic       load_pcard3,
   output logic       load_dcard1,
   output logic       load_dcard2,
   output logic       load_dcard3,
   output logic       done,
   output logic       player_win_light,
`ifdef BACCARAT_STATE_DBG_EN
   output logic       dealer_win_light,
   output logic [2:0] state_dbg
`else
   output logic       dealer_win_light
`endif
);

   state_t state_r;
   state_t state_n;
   logic   go_s;
   logic   natural_s;
   logic   bank_draw_s;

   banker_draw u_banker_draw (
      .dscore (dscore),
      .pcard3 (pcard3),
      .draw   (bank_draw_s)
   );

`ifdef BACCARAT_STATE_DBG_EN
   assign state_dbg = state_r;
`endif

   // State register; reset returns to the first deal state immediately.
   always_ff @(posedge slow_clock or posedge resetb) begin
      if (resetb) begin
         state_r <= S_P1;
      end else begin
         state_r <= state_n;
      end
   end

   // Next-state, strobe and light decode.
   always_comb begin
      state_n          = state_r;
      load_pcard1      = 1'b0;
      load_pcard2      = 1'b0;
      load_pcard3      = 1'b0;
      load_dcard1      = 1'b0;
      load_dcard2      = 1'b0;
      load_dcard3      = 1'b0;
      done             = 1'b0;
      player_win_light = 1'b0;
      dealer_win_light = 1'b0;
      // Reset must silence the strobes even while step is held high.
      go_s             = step & ~resetb;
      natural_s        = (pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN);

      case (state_r)
         S_P1: begin
            load_pcard1 = go_s;
            if (go_s) state_n = S_D1;
            else      state_n = S_P1;
         end
         S_D1: begin
            load_dcard1 = go_s;
            if (go_s) state_n = S_P2;
            else      state_n = S_D1;
         end
         S_P2: begin
            load_pcard2 = go_s;
            if (go_s) state_n = S_D2;
            else      state_n = S_P2;
         end
         S_D2: begin
            load_dcard2 = go_s;
            if (go_s) state_n = S_THIRD;
            else      state_n = S_D2;
         end
         S_THIRD: begin
            if (!go_s) begin
               state_n = S_THIRD;
            end else if (natural_s) begin
               state_n = S_DONE;
            end else if (pscore <= PLAYER_DRAW_MAX) begin
               load_pcard3 = 1'b1;
               state_n     = S_BANK3;
            end else if (dscore <= DEALER_DRAW_MAX) begin
               load_dcard3 = 1'b1;
               state_n     = S_DONE;
            end else begin
               state_n = S_DONE;
            end
         end
         S_BANK3: begin
            load_dcard3 = go_s & bank_draw_s;
            if (go_s) state_n = S_DONE;
            else      state_n = S_BANK3;
         end
         S_DONE: begin
            state_n = S_DONE;
            done    = 1'b1;
            if (pscore > dscore) begin
               player_win_light = 1'b1;
            end else if (dscore > pscore) begin
               dealer_win_light = 1'b1;
            end else begin
               player_win_light = 1'b1;
               dealer_win_light = 1'b1;
            end
         end
         default: begin
            state_n = S_P1;
         end
      endcase
   end

endmodule

// File: tb/tb_baccarat_sequencer.sv
// Self-checking bench for baccarat_sequencer: a directed table of rounds,
// randomized rounds scored by a tableau-based reference model, and
// hand-written step-gating and mid-round reset sequences.
module tb_baccarat_sequencer;

   localparam logic [5:0] M_P1 = 6'b100000;
   localparam logic [5:0] M_D1 = 6'b010000;
   localparam logic [5:0] M_P2 = 6'b001000;
   localparam logic [5:0] M_D2 = 6'b000100;
   localparam logic [5:0] M_P3 = 6'b000010;
   localparam logic [5:0] M_D3 = 6'b000001;
   localparam logic [5:0] M_NO = 6'b000000;

   typedef struct {
      logic [3:0] ps;
      logic [3:0] ds;
      logic [3:0] pc3;
      logic [5:0] third;
      logic       has_bank;
      logic [5:0] bank;
      logic [3:0] fps;
      logic [3:0] fds;
      logic [1:0] lights;
   } vec_t;

   logic       slow_clock = 1'b0;
   logic       resetb;
   logic       step;
   logic [3:0] pscore;
   logic [3:0] dscore;
   logic [3:0] pcard3;
   logic       load_pcard1, load_pcard2, load_pcard3;
   logic       load_dcard1, load_dcard2, load_dcard3;
   logic       done;
   logic       player_win_light;
   logic       dealer_win_light;
`ifdef BACCARAT_STATE_DBG_EN
   logic [2:0] state_dbg;
`endif
   logic [5:0] strobes;
   logic [1:0] lights;

   int total = 0;
   int bad   = 0;

   logic [9:0] bank_mask [8];
   logic [5:0] deal [4];
   vec_t       tbl [14];

   always #5 slow_clock = ~slow_clock;

   assign strobes = {load_pcard1, load_dcard1, load_pcard2, load_dcard2, load_pcard3, load_dcard3};
   assign lights  = {player_win_light, dealer_win_light};

   baccarat_sequencer dut (
      .slow_clock       (slow_clock),
      .resetb           (resetb),
      .step             (step),
      .pscore           (pscore),
      .dscore           (dscore),
      .pcard3           (pcard3),
      .load_pcard1      (load_pcard1),
      .load_pcard2      (load_pcard2),
      .load_pcard3      (load_pcard3),
      .load_dcard1      (load_dcard1),
      .load_dcard2      (load_dcard2),
      .load_dcard3      (load_dcard3),
      .done             (done),
      .player_win_light (player_win_light),
`ifdef BACCARAT_STATE_DBG_EN
      .dealer_win_light (dealer_win_light),
      .state_dbg        (state_dbg)
`else
      .dealer_win_light (dealer_win_light)
`endif
   );

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   // One clock: apply step, check outputs 1ns later, then move to 1ns past the edge.
   task automatic cyc(input logic st, input logic [5:0] exp_s, input logic exp_d,
                      input logic [1:0] exp_l, input string tag);
      step = st;
      #1;
      chk({tag, "_strobes"}, {2'b00, strobes}, {2'b00, exp_s});
      chk({tag, "_done"},    {7'b0, done},     {7'b0, exp_d});
      chk({tag, "_lights"},  {6'b0, lights},   {6'b0, exp_l});
      @(posedge slow_clock);
      #1;
   endtask

   task automatic do_reset();
      resetb = 1'b1;
      step   = 1'($urandom_range(0, 1));
      #1;
      chk("reset_strobes", {2'b00, strobes}, 8'd0);
      chk("reset_done",    {7'b0, done},     8'd0);
      chk("reset_lights",  {6'b0, lights},   8'd0);
      @(posedge slow_clock);
      #1;
      resetb = 1'b0;
      pcard3 = 4'd0;
   endtask

   function automatic logic [1:0] light_of(input logic [3:0] p, input logic [3:0] d);
      if (p > d)      return 2'b10;
      else if (d > p) return 2'b01;
      else            return 2'b11;
   endfunction

   function automatic vec_t mk(input logic [3:0] ps, input logic [3:0] ds, input logic [3:0] pc3,
                               input logic [5:0] third, input logic hb, input logic [5:0] bank,
                               input logic [3:0] fps, input logic [3:0] fds);
      vec_t v;
      v.ps = ps; v.ds = ds; v.pc3 = pc3; v.third = third; v.has_bank = hb;
      v.bank = bank; v.fps = fps; v.fds = fds; v.lights = light_of(fps, fds);
      return v;
   endfunction

   // Reference model: punto-banco rules applied to a round's scores.
   function automatic vec_t model(input logic [3:0] ps, input logic [3:0] ds, input logic [3:0] pc3,
                                  input logic [3:0] fps, input logic [3:0] fds);
      int   face;
      vec_t v;
      face = (pc3 >= 4'd10) ? 0 : int'(pc3);
      if (ps >= 4'd8 || ds >= 4'd8)
         v = mk(ps, ds, pc3, M_NO, 1'b0, M_NO, fps, fds);
      else if (ps <= 4'd5)
         v = mk(ps, ds, pc3, M_P3, 1'b1, bank_mask[ds[2:0]][face] ? M_D3 : M_NO, fps, fds);
      else
         v = mk(ps, ds, pc3, (ds <= 4'd5) ? M_D3 : M_NO, 1'b0, M_NO, fps, fds);
      return v;
   endfunction

   task automatic run_round(input vec_t v, input bit gaps);
      do_reset();
      for (int k = 0; k < 4; k++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               pscore = 4'($urandom_range(0, 9));
               dscore = 4'($urandom_range(0, 9));
               cyc(1'b0, M_NO, 1'b0, 2'b00, "idle");
            end
         end
         pscore = 4'($urandom_range(0, 9));
         dscore = 4'($urandom_range(0, 9));
         cyc(1'b1, deal[k], 1'b0, 2'b00, "deal");
      end
      pscore = v.ps;
      dscore = v.ds;
      pcard3 = 4'd0;
      if (gaps) cyc(1'b0, M_NO, 1'b0, 2'b00, "idle_third");
      cyc(1'b1, v.third, 1'b0, 2'b00, "third");
      if (v.has_bank) begin
         pcard3 = v.pc3;
         if (gaps) cyc(1'b0, M_NO, 1'b0, 2'b00, "idle_bank");
         cyc(1'b1, v.bank, 1'b0, 2'b00, "bank");
      end
      pscore = v.fps;
      dscore = v.fds;
      for (int k = 0; k < 3; k++) begin
         cyc(1'($urandom_range(0, 1)), M_NO, 1'b1, v.lights, "final");
      end
   endtask

   initial begin
      // Bit v set: dealer with this score draws against player third-card value v.
      bank_mask[0] = 10'b11_1111_1111;
      bank_mask[1] = 10'b11_1111_1111;
      bank_mask[2] = 10'b11_1111_1111;
      bank_mask[3] = 10'b10_1111_1111;
      bank_mask[4] = 10'b00_1111_1100;
      bank_mask[5] = 10'b00_1111_0000;
      bank_mask[6] = 10'b00_1100_0000;
      bank_mask[7] = 10'b00_0000_0000;
      deal[0] = M_P1; deal[1] = M_D1; deal[2] = M_P2; deal[3] = M_D2;

      tbl[0]  = mk(4'd9, 4'd3, 4'd0,  M_NO, 1'b0, M_NO, 4'd9, 4'd3);
      tbl[1]  = mk(4'd4, 4'd3, 4'd8,  M_P3, 1'b1, M_NO, 4'd2, 4'd3);
      tbl[2]  = mk(4'd2, 4'd6, 4'd7,  M_P3, 1'b1, M_D3, 4'd9, 4'd9);
      tbl[3]  = mk(4'd2, 4'd6, 4'd12, M_P3, 1'b1, M_NO, 4'd2, 4'd6);
      tbl[4]  = mk(4'd7, 4'd5, 4'd0,  M_D3, 1'b0, M_NO, 4'd7, 4'd5);
      tbl[5]  = mk(4'd6, 4'd6, 4'd0,  M_NO, 1'b0, M_NO, 4'd6, 4'd6);
      tbl[6]  = mk(4'd5, 4'd4, 4'd1,  M_P3, 1'b1, M_NO, 4'd6, 4'd4);
      tbl[7]  = mk(4'd5, 4'd4, 4'd2,  M_P3, 1'b1, M_D3, 4'd7, 4'd8);
      tbl[8]  = mk(4'd8, 4'd0, 4'd0,  M_NO, 1'b0, M_NO, 4'd8, 4'd0);
      tbl[9]  = mk(4'd0, 4'd7, 4'd13, M_P3, 1'b1, M_NO, 4'd0, 4'd7);
      tbl[10] = mk(4'd3, 4'd5, 4'd3,  M_P3, 1'b1, M_NO, 4'd6, 4'd5);
      tbl[11] = mk(4'd3, 4'd5, 4'd4,  M_P3, 1'b1, M_D3, 4'd7, 4'd1);
      tbl[12] = mk(4'd6, 4'd7, 4'd0,  M_NO, 1'b0, M_NO, 4'd6, 4'd7);
      tbl[13] = mk(4'd7, 4'd8, 4'd0,  M_NO, 1'b0, M_NO, 4'd7, 4'd8);

      resetb = 1'b1;
      step   = 1'b0;
      pscore = 4'd0;
      dscore = 4'd0;
      pcard3 = 4'd0;
      @(posedge slow_clock);
      #1;

      // Directed rounds.
      for (int i = 0; i < 14; i++) begin
         run_round(tbl[i], 1'b0);
      end

      // Step gating: park in S_P2 for 10 idle cycles, then one load_pcard2 only.
      do_reset();
      cyc(1'b1, M_P1, 1'b0, 2'b00, "gate_p1");
      cyc(1'b1, M_D1, 1'b0, 2'b00, "gate_d1");
      for (int k = 0; k < 10; k++) begin
         cyc(1'b0, M_NO, 1'b0, 2'b00, "gate_hold");
      end
      cyc(1'b1, M_P2, 1'b0, 2'b00, "gate_p2");
      cyc(1'b1, M_D2, 1'b0, 2'b00, "gate_d2");

      // Mid-round reset while load_dcard1 is high, between clock edges.
      do_reset();
      cyc(1'b1, M_P1, 1'b0, 2'b00, "mrst_p1");
      step = 1'b1;
      #1;
      chk("mrst_d1_high", {2'b00, strobes}, {2'b00, M_D1});
      #2;
      resetb = 1'b1;
      #1;
      chk("mrst_async_drop", {2'b00, strobes}, 8'd0);
      @(posedge slow_clock);
      #1;
      resetb = 1'b0;
      cyc(1'b1, M_P1, 1'b0, 2'b00, "mrst_after_p1");
      cyc(1'b1, M_D1, 1'b0, 2'b00, "mrst_after_d1");

      // Randomized rounds against the reference model.
      for (int i = 0; i < 60; i++) begin
         run_round(model(4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                         4'($urandom_range(1, 13)), 4'($urandom_range(0, 9)),
                         4'($urandom_range(0, 9))), 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
